execute_cc_stage: RTL and testbench
===================================

Name: execute_cc_stage

Overview:
- Sits directly downstream of the ALU in the execute stage.
- Captures ALU result valE plus ALU operands, maintains the condition-code register {ZF,SF,OF}, and evaluates the branch/cmov condition.
- Latches everything into the E->M pipeline register with stall/bubble control, feeding the memory stage.

Parameters:
WIDTH, 32, datapath width (matches ALU operand/result width)
RNONE, 4'hF, register ID meaning "no destination"
INOP, 4'h1, icode inserted on bubble/reset
IRRMOVQ, 4'h2, icode of rrmov/cmovXX (dstE squashed when condition false)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
e_valid  input  1  execute-stage instruction is valid
e_icode  input  4  instruction code
e_ifun  input  4  function code; condition selector for jXX/cmovXX
e_alufun  input  4  ALU function presented to ALU (0 add, 1 sub, 2 logical-and, 3 logical-xor)
e_aluA  input  WIDTH  ALU operand A
e_aluB  input  WIDTH  ALU operand B
e_valE  input  WIDTH  ALU result
e_valA  input  WIDTH  store data / pass-through value
e_dstE  input  4  destination register for valE
e_dstM  input  4  destination register for memory read
set_cc  input  1  this instruction updates condition codes
cc_inhibit  input  1  suppress CC update (exception downstream)
m_stall  input  1  hold E->M register contents
m_bubble  input  1  load NOP into E->M register
cc  output  3  {ZF,SF,OF} current condition codes
e_cnd  output  1  combinational condition result from current cc and e_ifun
M_valid  output  1  registered valid
M_icode  output  4  registered icode
M_cnd  output  1  registered e_cnd
M_valE  output  WIDTH  registered valE
M_valA  output  WIDTH  registered valA
M_dstE  output  4  registered dstE, after cmov squash
M_dstM  output  4  registered dstM

Behaviour:
- Reset, synchronous, when rst=1 at a clock edge:
  - cc = 3'b100 (ZF=1, SF=0, OF=0).
  - M_valid=0, M_icode=INOP, M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE.
  - rst overrides every other input, including mid-stall.
- CC update:
  - Happens at an edge iff e_valid & set_cc & ~cc_inhibit & ~m_stall & ~rst.
  - ZF = (e_valE == 0).
  - SF = e_valE[WIDTH-1].
  - OF for alufun=0: (aluA[msb]==aluB[msb]) & (valE[msb]!=aluA[msb]).
  - OF for alufun=1, where valE = aluA-aluB: (aluA[msb]!=aluB[msb]) & (valE[msb]!=aluA[msb]).
  - OF = 0 for alufun 2 and 3, and for any other alufun.
  - New cc is visible the cycle after the update edge.
- e_cnd is combinational from the registered cc, not from the CC value being computed this cycle:
  - ifun 0 (always): 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): ~ZF
  - ifun 5 (ge): ~(SF^OF)
  - ifun 6 (g): ~(SF^OF)&~ZF
  - ifun 7..15: 0
- E->M register, priority order rst > m_stall > m_bubble > load:
  - m_stall: all M_* outputs hold; cc also holds.
  - m_bubble (no stall): same values as reset for M_* only; cc is unaffected, so a set_cc instruction still updates cc unless stalled.
  - load: M_* <= e_*, M_cnd <= e_cnd, M_valid <= e_valid.
  - load with e_icode==IRRMOVQ and e_cnd==0: M_dstE <= RNONE.
  - load with e_valid=0: same as bubble.
- m_stall and m_bubble both high: stall wins.
- Latency: one cycle from e_* to M_*.
- Widths: no truncation; valE is passed through exactly as given.

Test Plan:
- Reset: assert rst 1 cycle -> cc=3'b100, M_valid=0, M_icode=1, M_dstE=M_dstM=F.
- Add with CC update: alufun=0, aluA=0xBE, aluB=0xAA, valE=0x168, set_cc=1, dstE=3 -> next cycle cc=000, M_valE=0x168, M_dstE=3.
- Sub with CC update: alufun=1, aluA=0xAA, aluB=0xBE, valE=0xFFFFFFEC -> cc=010.
- Overflow then condition: aluA=0x7FFFFFFF, aluB=1, alufun=0, valE=0x80000000 -> cc=011. Then ifun=2 (l) -> e_cnd=0; ifun=6 (g) -> e_cnd=1.
- cmov squash: cc=100, icode=2, ifun=4 (ne), dstE=5 -> M_cnd=0, M_dstE=F. Same with ifun=3 -> M_dstE=5.
- Stall/bubble/reset interplay:
  - Stall with set_cc=1 and valE=0 -> M_* and cc unchanged.
  - Stall plus bubble together -> hold.
  - Bubble alone -> M_icode=1, M_valid=0.
  - rst asserted during stall -> reset values.

Source files
------------

// File: rtl/execute_cc_stage_if.sv
// rtl/execute_cc_stage_if.sv - execute-stage inputs and E->M register outputs
// The master drives the execute-stage side; the slave is the CC/pipeline block.
interface execute_cc_stage_if #(
  parameter int WIDTH = 32
);
  logic             e_valid;
  logic [3:0]       e_icode;
  logic [3:0]       e_ifun;
  logic [3:0]       e_alufun;
  logic [WIDTH-1:0] e_aluA;
  logic [WIDTH-1:0] e_aluB;
  logic [WIDTH-1:0] e_valE;
  logic [WIDTH-1:0] e_valA;
  logic [3:0]       e_dstE;
  logic [3:0]       e_dstM;
  logic             set_cc;
  logic             cc_inhibit;
  logic             m_stall;
  logic             m_bubble;
  logic [2:0]       cc;
  logic             e_cnd;
  logic             M_valid;
  logic [3:0]       M_icode;
  logic             M_cnd;
  logic [WIDTH-1:0] M_valE;
  logic [WIDTH-1:0] M_valA;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;

  modport master (
    output e_valid, e_icode, e_ifun, e_alufun, e_aluA, e_aluB, e_valE, e_valA,
           e_dstE, e_dstM, set_cc, cc_inhibit, m_stall, m_bubble,
    input  cc, e_cnd, M_valid, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  e_valid, e_icode, e_ifun, e_alufun, e_aluA, e_aluB, e_valE, e_valA,
           e_dstE, e_dstM, set_cc, cc_inhibit, m_stall, m_bubble,
    output cc, e_cnd, M_valid, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/execute_cc_stage.sv
// rtl/execute_cc_stage.sv - condition codes, branch/cmov condition, E->M register
// e_cnd is evaluated from the registered cc, never from the value being computed.
module execute_cc_stage #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] RNONE   = 4'hF,
  parameter logic [3:0] INOP    = 4'h1,
  parameter logic [3:0] IRRMOVQ = 4'h2
) (
  input logic clk,
  input logic rst,
  execute_cc_stage_if.slave bus
);

  logic [2:0] ccReg;
  logic       zf, sf, of;
  logic       aMsb, bMsb, rMsb;
  logic       newOf;
  logic       cnd;
  logic       ccUpdate;
  logic       loadNop;

  assign {zf, sf, of} = ccReg;
  assign aMsb = bus.e_aluA[WIDTH-1];
  assign bMsb = bus.e_aluB[WIDTH-1];
  assign rMsb = bus.e_valE[WIDTH-1];

  always_comb begin
    newOf = 1'b0;
    case (bus.e_alufun)
      4'd0:    newOf = (aMsb == bMsb) && (rMsb != aMsb);
      4'd1:    newOf = (aMsb != bMsb) && (rMsb != aMsb);
      default: newOf = 1'b0;
    endcase
  end

  always_comb begin
    cnd = 1'b0;
    case (bus.e_ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (sf ^ of) | zf;
      4'd2:    cnd = sf ^ of;
      4'd3:    cnd = zf;
      4'd4:    cnd = ~zf;
      4'd5:    cnd = ~(sf ^ of);
      4'd6:    cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  assign ccUpdate = bus.e_valid & bus.set_cc & ~bus.cc_inhibit & ~bus.m_stall;
  // An invalid instruction enters the memory stage as a NOP, same as a bubble.
  assign loadNop  = ~bus.m_stall & (bus.m_bubble | ~bus.e_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      ccReg <= 3'b100;
    end else if (ccUpdate) begin
      ccReg <= {(bus.e_valE == '0), rMsb, newOf};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || loadNop) begin
      bus.M_valid <= 1'b0;
      bus.M_icode <= INOP;
      bus.M_cnd   <= 1'b0;
      bus.M_valE  <= '0;
      bus.M_valA  <= '0;
      bus.M_dstE  <= RNONE;
      bus.M_dstM  <= RNONE;
    end else if (!bus.m_stall) begin
      bus.M_valid <= bus.e_valid;
      bus.M_icode <= bus.e_icode;
      bus.M_cnd   <= cnd;
      bus.M_valE  <= bus.e_valE;
      bus.M_valA  <= bus.e_valA;
      bus.M_dstE  <= (bus.e_icode == IRRMOVQ && !cnd) ? RNONE : bus.e_dstE;
      bus.M_dstM  <= bus.e_dstM;
    end
  end

  assign bus.cc    = ccReg;
  assign bus.e_cnd = cnd;

endmodule

// File: tb/tb_execute_cc_stage.sv
// tb/tb_execute_cc_stage.sv - directed vector table plus randomized model check
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_execute_cc_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_cc_stage_if #(.WIDTH(32)) bus ();

  execute_cc_stage #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst, valid;
    logic [3:0]  icode, ifun, alufun;
    logic [31:0] aluA, aluB, valE, valA;
    logic [3:0]  dstE, dstM;
    logic        setCc, inhibit, stall, bubble;
    logic        expCnd;
    logic [2:0]  expCc;
    logic        expValid;
    logic [3:0]  expIcode;
    logic        expMCnd;
    logic [31:0] expValE, expValA;
    logic [3:0]  expDstE, expDstM;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] af, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ve, input logic [31:0] va, input logic [3:0] de,
                       input logic [3:0] dm, input logic sc, input logic inh,
                       input logic st, input logic bb);
    rst = r; bus.e_valid = v; bus.e_icode = ic; bus.e_ifun = fn; bus.e_alufun = af;
    bus.e_aluA = a; bus.e_aluB = b; bus.e_valE = ve; bus.e_valA = va;
    bus.e_dstE = de; bus.e_dstM = dm; bus.set_cc = sc; bus.cc_inhibit = inh;
    bus.m_stall = st; bus.m_bubble = bb;
  endtask

  // Reference state of the model: condition codes as flags, E->M contents as fields.
  logic        mZf, mSf, mOf;
  logic        mValid, mCnd;
  logic [3:0]  mIcode, mDstE, mDstM;
  logic [31:0] mValE, mValA;

  function automatic logic condOf(input logic [3:0] fn, input logic z, input logic s, input logic o);
    logic lt;
    lt = s ^ o;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || z;
      4'd2: return lt;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !lt;
      4'd6: return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Signed overflow judged by whether the exact result fits in 32 signed bits.
  function automatic logic ovfOf(input logic [3:0] af, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint r;
    sa = a; sb = b;
    if (af == 4'd0) r = longint'(sa) + longint'(sb);
    else if (af == 4'd1) r = longint'(sa) - longint'(sb);
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic modelReset();
    {mZf, mSf, mOf} = 3'b100;
    mValid = 0; mIcode = 4'h1; mCnd = 0; mValE = 0; mValA = 0; mDstE = 4'hF; mDstM = 4'hF;
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1,0,4'h0,4'h0,4'h0,32'h0,32'h0,32'h0,32'h0,4'hF,4'hF,0,0,0,0, 1,3'b100,0,4'h1,0,32'h0,32'h0,4'hF,4'hF};
    vecs[1]  = '{0,1,4'h6,4'h0,4'h0,32'hBE,32'hAA,32'h168,32'h11,4'h3,4'hF,1,0,0,0, 1,3'b000,1,4'h6,1,32'h168,32'h11,4'h3,4'hF};
    vecs[2]  = '{0,1,4'h6,4'h0,4'h1,32'hAA,32'hBE,32'hFFFFFFEC,32'h22,4'h4,4'hF,1,0,0,0, 1,3'b010,1,4'h6,1,32'hFFFFFFEC,32'h22,4'h4,4'hF};
    vecs[3]  = '{0,1,4'h6,4'h0,4'h0,32'h7FFFFFFF,32'h1,32'h80000000,32'h33,4'h5,4'hF,1,0,0,0, 1,3'b011,1,4'h6,1,32'h80000000,32'h33,4'h5,4'hF};
    vecs[4]  = '{0,1,4'h7,4'h2,4'h0,32'h0,32'h0,32'h100,32'h44,4'hF,4'hF,0,0,0,0, 0,3'b011,1,4'h7,0,32'h100,32'h44,4'hF,4'hF};
    vecs[5]  = '{0,1,4'h7,4'h6,4'h0,32'h0,32'h0,32'h200,32'h55,4'hF,4'hF,0,0,0,0, 1,3'b011,1,4'h7,1,32'h200,32'h55,4'hF,4'hF};
    vecs[6]  = '{1,1,4'h6,4'h0,4'h0,32'h0,32'h0,32'h0,32'h0,4'hF,4'hF,1,0,0,0, 1,3'b100,0,4'h1,0,32'h0,32'h0,4'hF,4'hF};
    vecs[7]  = '{0,1,4'h2,4'h4,4'h0,32'h0,32'h0,32'h55,32'h55,4'h5,4'hF,0,0,0,0, 0,3'b100,1,4'h2,0,32'h55,32'h55,4'hF,4'hF};
    vecs[8]  = '{0,1,4'h2,4'h3,4'h0,32'h0,32'h0,32'h66,32'h66,4'h5,4'hF,0,0,0,0, 1,3'b100,1,4'h2,1,32'h66,32'h66,4'h5,4'hF};
    vecs[9]  = '{0,1,4'h6,4'h0,4'h0,32'h1,32'h2,32'h3,32'h77,4'h7,4'hF,1,0,0,0, 1,3'b000,1,4'h6,1,32'h3,32'h77,4'h7,4'hF};
    vecs[10] = '{0,1,4'h6,4'h0,4'h0,32'h0,32'h0,32'h0,32'h88,4'h8,4'hF,1,0,1,0, 1,3'b000,1,4'h6,1,32'h3,32'h77,4'h7,4'hF};
    vecs[11] = '{0,1,4'h6,4'h0,4'h0,32'h0,32'h0,32'h0,32'h99,4'h8,4'hF,1,0,1,1, 1,3'b000,1,4'h6,1,32'h3,32'h77,4'h7,4'hF};
    vecs[12] = '{0,1,4'h6,4'h0,4'h0,32'h0,32'h0,32'h0,32'hAA,4'h8,4'hF,1,0,0,1, 1,3'b100,0,4'h1,0,32'h0,32'h0,4'hF,4'hF};
    vecs[13] = '{0,1,4'h5,4'h0,4'h0,32'h0,32'h0,32'h1234,32'hBB,4'hF,4'hA,0,0,0,0, 1,3'b100,1,4'h5,1,32'h1234,32'hBB,4'hF,4'hA};
    vecs[14] = '{0,1,4'h6,4'h0,4'h1,32'h0,32'h1,32'hFFFFFFFF,32'hCC,4'h2,4'hF,1,1,0,0, 1,3'b100,1,4'h6,1,32'hFFFFFFFF,32'hCC,4'h2,4'hF};
    vecs[15] = '{0,0,4'h6,4'h0,4'h0,32'h0,32'h0,32'hFFFFFFFF,32'hDD,4'h2,4'hF,1,0,0,0, 1,3'b100,0,4'h1,0,32'h0,32'h0,4'hF,4'hF};
    vecs[16] = '{0,1,4'h6,4'h9,4'h0,32'h8,32'h8,32'h10,32'hEE,4'h3,4'hF,1,0,0,0, 0,3'b000,1,4'h6,0,32'h10,32'hEE,4'h3,4'hF};
    vecs[17] = '{1,1,4'h6,4'h0,4'h0,32'h0,32'h0,32'h0,32'h0,4'h3,4'hF,1,0,1,0, 1,3'b100,0,4'h1,0,32'h0,32'h0,4'hF,4'hF};

    drive(1,0,0,0,0,0,0,0,0,4'hF,4'hF,0,0,0,0);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].icode, vecs[i].ifun, vecs[i].alufun,
            vecs[i].aluA, vecs[i].aluB, vecs[i].valE, vecs[i].valA, vecs[i].dstE,
            vecs[i].dstM, vecs[i].setCc, vecs[i].inhibit, vecs[i].stall, vecs[i].bubble);
      #1;
      chk($sformatf("v%0d e_cnd", i), 32'(bus.e_cnd), 32'(vecs[i].expCnd));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d cc", i), 32'(bus.cc), 32'(vecs[i].expCc));
      chk($sformatf("v%0d M_valid", i), 32'(bus.M_valid), 32'(vecs[i].expValid));
      chk($sformatf("v%0d M_icode", i), 32'(bus.M_icode), 32'(vecs[i].expIcode));
      chk($sformatf("v%0d M_cnd", i), 32'(bus.M_cnd), 32'(vecs[i].expMCnd));
      chk($sformatf("v%0d M_valE", i), bus.M_valE, vecs[i].expValE);
      chk($sformatf("v%0d M_valA", i), bus.M_valA, vecs[i].expValA);
      chk($sformatf("v%0d M_dstE", i), 32'(bus.M_dstE), 32'(vecs[i].expDstE));
      chk($sformatf("v%0d M_dstM", i), 32'(bus.M_dstM), 32'(vecs[i].expDstM));
    end

    // The last vector was a reset, so the model starts from reset state.
    modelReset();
    for (int n = 0; n < 400; n++) begin
      logic        r, v, sc, inh, st, bb, expCnd;
      logic [3:0]  ic, fn, af, de, dm;
      logic [31:0] a, b, ve, va;
      r   = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 7) != 0);
      ic  = ($urandom_range(0, 2) == 0) ? 4'h2 : 4'($urandom_range(0, 15));
      fn  = 4'($urandom_range(0, 9));
      af  = 4'($urandom_range(0, 4));
      a   = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      case (af)
        4'd0: ve = a + b;
        4'd1: ve = a - b;
        4'd2: ve = a & b;
        4'd3: ve = a ^ b;
        default: ve = $urandom;
      endcase
      va  = $urandom;
      de  = 4'($urandom_range(0, 15));
      dm  = 4'($urandom_range(0, 15));
      sc  = ($urandom_range(0, 1) == 0);
      inh = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 5) == 0);
      bb  = ($urandom_range(0, 5) == 0);
      drive(r, v, ic, fn, af, a, b, ve, va, de, dm, sc, inh, st, bb);
      expCnd = condOf(fn, mZf, mSf, mOf);
      #1;
      chk($sformatf("r%0d e_cnd", n), 32'(bus.e_cnd), 32'(expCnd));
      @(posedge clk);
      if (r) begin
        modelReset();
      end else begin
        if (v && sc && !inh && !st) begin
          mZf = (ve == 0);
          mSf = ve[31];
          mOf = ovfOf(af, a, b);
        end
        if (!st) begin
          if (bb || !v) begin
            mValid = 0; mIcode = 4'h1; mCnd = 0; mValE = 0; mValA = 0; mDstE = 4'hF; mDstM = 4'hF;
          end else begin
            mValid = 1; mIcode = ic; mCnd = expCnd; mValE = ve; mValA = va; mDstM = dm;
            mDstE = (ic == 4'h2 && !expCnd) ? 4'hF : de;
          end
        end
      end
      @(negedge clk);
      chk($sformatf("r%0d cc", n), 32'(bus.cc), 32'({mZf, mSf, mOf}));
      chk($sformatf("r%0d M_valid", n), 32'(bus.M_valid), 32'(mValid));
      chk($sformatf("r%0d M_icode", n), 32'(bus.M_icode), 32'(mIcode));
      chk($sformatf("r%0d M_cnd", n), 32'(bus.M_cnd), 32'(mCnd));
      chk($sformatf("r%0d M_valE", n), bus.M_valE, mValE);
      chk($sformatf("r%0d M_valA", n), bus.M_valA, mValA);
      chk($sformatf("r%0d M_dstE", n), 32'(bus.M_dstE), 32'(mDstE));
      chk($sformatf("r%0d M_dstM", n), 32'(bus.M_dstM), 32'(mDstM));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
